// File: rtl/oserdes_tx_sequencer.sv
// Byte-level transmit sequencer feeding the oserdes8x parallel data input.
// Emits training bursts and idle fill, and frames payload as SOF, stuffed bytes, CRC-8, EOF.
module oserdes_tx_sequencer #(
  parameter int unsigned TRAIN_CYCLES  = 64,
  parameter logic [7:0]  TRAIN_PATTERN = 8'hF0,
  parameter logic [7:0]  IDLE_BYTE     = 8'hBC,
  parameter logic [7:0]  SOF_BYTE      = 8'hFB,
  parameter logic [7:0]  EOF_BYTE      = 8'hFD,
  parameter logic [7:0]  ESC_BYTE      = 8'h7D,
  parameter logic [7:0]  ESC_XOR       = 8'h20
) (
  input  logic        clk,
  input  logic        reset_clkdiv,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  input  logic        retrain,
  output logic [7:0]  tx_data,
  output logic        training,
  output logic        busy,
  output logic [15:0] frame_count
);

  localparam int unsigned CW = $clog2(TRAIN_CYCLES + 1);
  localparam logic [CW-1:0] TRAIN_LAST = CW'(TRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_TRAIN   = 3'd0,
    ST_IDLE    = 3'd1,
    ST_SOF     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CRC     = 3'd4,
    ST_EOF     = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] train_cnt_q, train_cnt_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          training_q, training_d;
  logic          busy_q, busy_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic [7:0]    crc_q, crc_d;
  logic          esc_pending_q, esc_pending_d;
  logic [7:0]    esc_byte_q, esc_byte_d;
  logic          last_q, last_d;
  logic          retrain_pending_q, retrain_pending_d;
  logic          in_frame_s;

  // CRC-8, poly 0x07, MSB-first, one byte per call.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    c = crc ^ d;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic needs_esc(input logic [7:0] b);
    return (b == SOF_BYTE) || (b == EOF_BYTE) || (b == ESC_BYTE) || (b == IDLE_BYTE);
  endfunction

  assign in_frame_s = (state_q == ST_SOF) || (state_q == ST_PAYLOAD) ||
                      (state_q == ST_CRC) || (state_q == ST_EOF);
  assign s_ready    = (state_q == ST_PAYLOAD) && !esc_pending_q;

  // Next-state and byte selection for the registered outputs.
  always_comb begin
    state_d           = state_q;
    train_cnt_d       = train_cnt_q;
    tx_data_d         = IDLE_BYTE;
    frame_count_d     = frame_count_q;
    crc_d             = crc_q;
    esc_pending_d     = esc_pending_q;
    esc_byte_d        = esc_byte_q;
    last_d            = last_q;
    retrain_pending_d = retrain_pending_q;

    if (retrain && in_frame_s) begin
      retrain_pending_d = 1'b1;
    end else begin
      retrain_pending_d = retrain_pending_q;
    end

    case (state_q)
      ST_TRAIN: begin
        tx_data_d = TRAIN_PATTERN;
        if (train_cnt_q == TRAIN_LAST) begin
          train_cnt_d = '0;
          state_d     = ST_IDLE;
        end else begin
          train_cnt_d = train_cnt_q + CW'(1);
        end
      end
      ST_IDLE: begin
        tx_data_d = IDLE_BYTE;
        if (retrain || retrain_pending_q) begin
          retrain_pending_d = 1'b0;
          state_d           = ST_TRAIN;
        end else if (s_valid) begin
          state_d = ST_SOF;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SOF: begin
        tx_data_d = SOF_BYTE;
        crc_d     = 8'h00;
        state_d   = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (esc_pending_q) begin
          tx_data_d     = esc_byte_q;
          esc_pending_d = 1'b0;
          state_d       = last_q ? ST_CRC : ST_PAYLOAD;
        end else if (s_valid) begin
          crc_d  = crc8_byte(crc_q, s_data);
          last_d = s_last;
          if (needs_esc(s_data)) begin
            tx_data_d     = ESC_BYTE;
            esc_pending_d = 1'b1;
            esc_byte_d    = s_data ^ ESC_XOR;
          end else begin
            tx_data_d = s_data;
            state_d   = s_last ? ST_CRC : ST_PAYLOAD;
          end
        end else begin
          tx_data_d = IDLE_BYTE;
        end
      end
      ST_CRC: begin
        if (esc_pending_q) begin
          tx_data_d     = esc_byte_q;
          esc_pending_d = 1'b0;
          state_d       = ST_EOF;
        end else if (needs_esc(crc_q)) begin
          tx_data_d     = ESC_BYTE;
          esc_pending_d = 1'b1;
          esc_byte_d    = crc_q ^ ESC_XOR;
        end else begin
          tx_data_d = crc_q;
          state_d   = ST_EOF;
        end
      end
      ST_EOF: begin
        tx_data_d     = EOF_BYTE;
        frame_count_d = frame_count_q + 16'd1;
        state_d       = ST_IDLE;
      end
      default: begin
        tx_data_d = TRAIN_PATTERN;
        state_d   = ST_TRAIN;
      end
    endcase

    training_d = (state_q == ST_TRAIN);
    busy_d     = in_frame_s;
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk or posedge reset_clkdiv) begin
    if (reset_clkdiv) begin
      state_q           <= ST_TRAIN;
      train_cnt_q       <= '0;
      tx_data_q         <= TRAIN_PATTERN;
      training_q        <= 1'b1;
      busy_q            <= 1'b0;
      frame_count_q     <= 16'h0000;
      crc_q             <= 8'h00;
      esc_pending_q     <= 1'b0;
      esc_byte_q        <= 8'h00;
      last_q            <= 1'b0;
      retrain_pending_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      train_cnt_q       <= train_cnt_d;
      tx_data_q         <= tx_data_d;
      training_q        <= training_d;
      busy_q            <= busy_d;
      frame_count_q     <= frame_count_d;
      crc_q             <= crc_d;
      esc_pending_q     <= esc_pending_d;
      esc_byte_q        <= esc_byte_d;
      last_q            <= last_d;
      retrain_pending_q <= retrain_pending_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign training    = training_q;
  assign busy        = busy_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_oserdes_tx_sequencer.sv
// Scoreboard bench for oserdes_tx_sequencer: stimulus queues expected per-cycle outputs,
// a monitor pops and compares one row per falling clock edge (or on async reset).
module tb_oserdes_tx_sequencer;

  logic        clk          = 1'b0;
  logic        reset_clkdiv = 1'b1;
  logic [7:0]  s_data       = 8'h00;
  logic        s_valid      = 1'b0;
  logic        s_last       = 1'b0;
  logic        retrain      = 1'b0;
  logic        s_ready;
  logic [7:0]  tx_data;
  logic        training;
  logic        busy;
  logic [15:0] frame_count;

  oserdes_tx_sequencer dut (
    .clk          (clk),
    .reset_clkdiv (reset_clkdiv),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .retrain      (retrain),
    .tx_data      (tx_data),
    .training     (training),
    .busy         (busy),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [7:0]  tx;
    logic        rdy;
    logic        trn;
    logic        bsy;
    logic [15:0] fc;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic ex(input string tag, input logic [7:0] tx, input logic rdy,
                    input logic trn, input logic bsy, input logic [15:0] fc);
    exp_t e;
    e.tag = tag; e.tx = tx; e.rdy = rdy; e.trn = trn; e.bsy = bsy; e.fc = fc;
    sb_q.push_back(e);
  endtask

  task automatic ex_rep(input int n, input string tag, input logic [7:0] tx, input logic rdy,
                        input logic trn, input logic bsy, input logic [15:0] fc);
    for (int i = 0; i < n; i++) ex(tag, tx, rdy, trn, bsy, fc);
  endtask

  // Monitor: one expected row per presented output cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or posedge reset_clkdiv);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        vectors++;
        if (tx_data !== e.tx || s_ready !== e.rdy || training !== e.trn ||
            busy !== e.bsy || frame_count !== e.fc) begin
          miscompares++;
          $display("FAIL %s: got tx=%h rdy=%b trn=%b busy=%b fc=%0d, need tx=%h rdy=%b trn=%b busy=%b fc=%0d",
                   e.tag, tx_data, s_ready, training, busy, frame_count,
                   e.tx, e.rdy, e.trn, e.bsy, e.fc);
        end
      end
    end
  end

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while (sb_q.size() > 0 && n < max_cycles) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d rows pending, need 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!s_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: got s_ready=0 for byte %h, need 1", d);
    end
    @(posedge clk); #1;
  endtask

  task automatic phase_start();
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state while reset is held.
    repeat (3) @(posedge clk);
    #1;
    ex("reset_hold", 8'hF0, 1'b0, 1'b1, 1'b0, 16'd0);
    wait_drain(10);

    // Training burst after release: reset value plus 64 trained cycles, then idle fill.
    phase_start();
    reset_clkdiv = 1'b0;
    ex_rep(65, "train_burst", 8'hF0, 1'b0, 1'b1, 1'b0, 16'd0);
    ex_rep(3,  "post_train_idle", 8'hBC, 1'b0, 1'b0, 1'b0, 16'd0);
    wait_drain(200);

    // Plain 3-byte frame, s_valid held.
    phase_start();
    ex("f1_idle",  8'hBC, 1'b0, 1'b0, 1'b0, 16'd0);
    ex("f1_idle2", 8'hBC, 1'b0, 1'b0, 1'b0, 16'd0);
    ex("f1_sof",   8'hFB, 1'b1, 1'b0, 1'b1, 16'd0);
    ex("f1_b01",   8'h01, 1'b1, 1'b0, 1'b1, 16'd0);
    ex("f1_b02",   8'h02, 1'b1, 1'b0, 1'b1, 16'd0);
    ex("f1_b03",   8'h03, 1'b0, 1'b0, 1'b1, 16'd0);
    ex("f1_crc",   8'h48, 1'b0, 1'b0, 1'b1, 16'd0);
    ex("f1_eof",   8'hFD, 1'b0, 1'b0, 1'b1, 16'd1);
    ex("f1_gap",   8'hBC, 1'b0, 1'b0, 1'b0, 16'd1);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b1);
    s_valid = 1'b0;
    wait_drain(30);

    // Single escaped byte 7D, CRC 74.
    phase_start();
    ex("f2_idle",  8'hBC, 1'b0, 1'b0, 1'b0, 16'd1);
    ex("f2_idle2", 8'hBC, 1'b0, 1'b0, 1'b0, 16'd1);
    ex("f2_sof",   8'hFB, 1'b1, 1'b0, 1'b1, 16'd1);
    ex("f2_esc",   8'h7D, 1'b0, 1'b0, 1'b1, 16'd1);
    ex("f2_5d",    8'h5D, 1'b0, 1'b0, 1'b1, 16'd1);
    ex("f2_crc",   8'h74, 1'b0, 1'b0, 1'b1, 16'd1);
    ex("f2_eof",   8'hFD, 1'b0, 1'b0, 1'b1, 16'd2);
    ex("f2_gap",   8'hBC, 1'b0, 1'b0, 1'b0, 16'd2);
    send_byte(8'h7D, 1'b1);
    s_valid = 1'b0;
    wait_drain(30);

    // Underrun of two cycles between 01 and 02; CRC unaffected by filler.
    phase_start();
    ex("f3_idle",  8'hBC, 1'b0, 1'b0, 1'b0, 16'd2);
    ex("f3_idle2", 8'hBC, 1'b0, 1'b0, 1'b0, 16'd2);
    ex("f3_sof",   8'hFB, 1'b1, 1'b0, 1'b1, 16'd2);
    ex("f3_b01",   8'h01, 1'b1, 1'b0, 1'b1, 16'd2);
    ex("f3_fill1", 8'hBC, 1'b1, 1'b0, 1'b1, 16'd2);
    ex("f3_fill2", 8'hBC, 1'b1, 1'b0, 1'b1, 16'd2);
    ex("f3_b02",   8'h02, 1'b1, 1'b0, 1'b1, 16'd2);
    ex("f3_b03",   8'h03, 1'b0, 1'b0, 1'b1, 16'd2);
    ex("f3_crc",   8'h48, 1'b0, 1'b0, 1'b1, 16'd2);
    ex("f3_eof",   8'hFD, 1'b0, 1'b0, 1'b1, 16'd3);
    ex("f3_gap",   8'hBC, 1'b0, 1'b0, 1'b0, 16'd3);
    send_byte(8'h01, 1'b0);
    s_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b1);
    s_valid = 1'b0;
    wait_drain(30);

    // Retrain pulse mid-frame: frame completes, one idle, then a full burst.
    phase_start();
    ex("f4_idle",  8'hBC, 1'b0, 1'b0, 1'b0, 16'd3);
    ex("f4_idle2", 8'hBC, 1'b0, 1'b0, 1'b0, 16'd3);
    ex("f4_sof",   8'hFB, 1'b1, 1'b0, 1'b1, 16'd3);
    ex("f4_b01",   8'h01, 1'b1, 1'b0, 1'b1, 16'd3);
    ex("f4_b02",   8'h02, 1'b1, 1'b0, 1'b1, 16'd3);
    ex("f4_b03",   8'h03, 1'b0, 1'b0, 1'b1, 16'd3);
    ex("f4_crc",   8'h48, 1'b0, 1'b0, 1'b1, 16'd3);
    ex("f4_eof",   8'hFD, 1'b0, 1'b0, 1'b1, 16'd4);
    ex("f4_gap",   8'hBC, 1'b0, 1'b0, 1'b0, 16'd4);
    ex_rep(64, "f4_retrain", 8'hF0, 1'b0, 1'b1, 1'b0, 16'd4);
    ex_rep(2,  "f4_idle_after", 8'hBC, 1'b0, 1'b0, 1'b0, 16'd4);
    send_byte(8'h01, 1'b0);
    retrain = 1'b1;
    send_byte(8'h02, 1'b0);
    retrain = 1'b0;
    send_byte(8'h03, 1'b1);
    s_valid = 1'b0;
    wait_drain(200);

    // Asynchronous reset mid-payload takes effect before the next clock edge.
    phase_start();
    ex("f5_idle",  8'hBC, 1'b0, 1'b0, 1'b0, 16'd4);
    ex("f5_idle2", 8'hBC, 1'b0, 1'b0, 1'b0, 16'd4);
    ex("f5_sof",   8'hFB, 1'b1, 1'b0, 1'b1, 16'd4);
    ex("f5_b01",   8'h01, 1'b1, 1'b0, 1'b1, 16'd4);
    s_data  = 8'h01;
    s_last  = 1'b0;
    s_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    ex("async_reset", 8'hF0, 1'b0, 1'b1, 1'b0, 16'd0);
    reset_clkdiv = 1'b1;
    wait_drain(10);
    s_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
